serial_byte_assembler: RTL and testbench
========================================

Name: serial_byte_assembler

Overview:
- Upstream feeder for the 8-bit enable-loaded register stage: converts a framed serial bit stream into parallel words.
- Drives the register's data input from data_out and its load enable from load.
- Each completed word produces exactly one load pulse, so the register captures once per word and holds between words.

Parameters:
- WIDTH, 8: bits per assembled word; matches the downstream register width.
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock shared with the downstream register.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- frame  input  1  high while a transfer is in progress; low = idle/abort.
- bit_valid  input  1  bit_in is sampled on this edge when frame && bit_valid.
- bit_in  input  1  serial data bit.
- data_out  output  WIDTH  last completed word; connects to register d.
- load  output  1  one-cycle pulse when data_out updates; connects to register en.
- abort  output  1  one-cycle pulse when frame drops mid-word.
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, bit counter=0, data_out=0, load=0, abort=0, busy=0. Takes effect immediately regardless of clk. Normal operation resumes on the first rising edge after rst returns high.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on an edge with frame=1. A bit presented with bit_valid on that same edge is accepted as bit 0.
  - SHIFT -> IDLE on an edge with frame=0.
- Bit acceptance: only when frame=1 && bit_valid=1. bit_valid=0 cycles are gaps; the counter and shift register hold.
- Counter runs 0..WIDTH-1. On the edge accepting the WIDTH-th bit:
  - data_out <= assembled word (including this bit).
  - load <= 1 for exactly one cycle.
  - Counter <= 0.
  - State stays SHIFT if frame=1, so back-to-back words need no idle cycle.
- Latency: data_out and load are valid after the edge that samples the last bit. The downstream register captures on the following edge.
- Frame drop (frame=0 in SHIFT):
  - Counter != 0: partial word discarded, abort=1 for one cycle, counter <= 0, data_out unchanged, load=0.
  - Counter == 0: silent return to IDLE, no abort.
- bit_valid=1 with frame=0: ignored.
- busy = (state==SHIFT).
- data_out holds its value indefinitely between loads; never shows partial words.
- Reset mid-word: partial word and data_out both cleared to 0; no load or abort pulse is generated.

Test Plan:
- Basic word, MSB_FIRST=1: rst low 2 cycles, then frame=1 and 8 consecutive valid bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5, load high exactly one cycle after the 8th bit edge, busy=1 throughout.
- Gapped bits: same A5 bit sequence with bit_valid=0 for 3 cycles between bits 3 and 4 -> data_out=8'hA5, single load pulse, no early load.
- Abort: after A5 completes, send 3 bits 1,1,1 then frame=0 -> abort one-cycle pulse, data_out stays 8'hA5, load stays 0. Next full frame 0,0,1,1,1,1,0,0 -> data_out=8'h3C.
- Back-to-back: frame held high, 16 valid bits (A5 pattern then eight 1s) on consecutive cycles -> load pulses 8 cycles apart, data_out 8'hA5 then 8'hFF.
- Bit order: send 1,0,0,0,0,0,0,0 -> MSB_FIRST=1 instance gives 8'h80; MSB_FIRST=0 instance gives 8'h01.
- Async reset mid-word: after 4 bits, drive rst=0 between clock edges -> data_out=0, busy=0 immediately, no load or abort. After release, a full 8'hA5 frame assembles correctly from bit 0.

Source files
------------

// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler
// Collects framed serial bits into WIDTH-bit words for an enable-loaded register.
// data_out is written only when a full word is complete, and load pulses for one
// cycle at the same time. A frame that drops mid-word discards the partial word
// and pulses abort instead.
module serial_byte_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             abort,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_nxt;
    logic             load_nxt;
    logic             abort_nxt;
    logic             accept;

    // Shift register contents after taking bit_in in the configured bit order.
    always_comb begin
        if (MSB_FIRST) begin
            word = {shreg[WIDTH-2:0], bit_in};
        end else begin
            word = {bit_in, shreg[WIDTH-1:1]};
        end
    end

    // Next state, bit acceptance, word completion and abort detection.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        data_nxt  = data_out;
        load_nxt  = 1'b0;
        abort_nxt = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                if (frame) begin
                    state_nxt = SHIFT;
                    accept    = bit_valid;
                end
            end
            SHIFT: begin
                if (!frame) begin
                    state_nxt = IDLE;
                    abort_nxt = (count != '0);
                    count_nxt = '0;
                    shreg_nxt = '0;
                end else begin
                    accept = bit_valid;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                shreg_nxt = '0;
            end
        endcase

        if (accept) begin
            if (count == LAST) begin
                data_nxt  = word;
                load_nxt  = 1'b1;
                count_nxt = '0;
                shreg_nxt = '0;
            end else begin
                count_nxt = count + CW'(1);
                shreg_nxt = word;
            end
        end
    end

    // State and output registers; reset clears any partial word and the output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            shreg    <= '0;
            data_out <= '0;
            load     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            shreg    <= shreg_nxt;
            data_out <= data_nxt;
            load     <= load_nxt;
            abort    <= abort_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_byte_assembler.sv
// tb_serial_byte_assembler
// Drives one MSB-first and one LSB-first assembler from the same inputs and checks
// both against a bit-queue model every cycle, plus directed literal expectations.
module tb_serial_byte_assembler;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             frame;
    logic             bit_valid;
    logic             bit_in;
    logic [WIDTH-1:0] data_msb;
    logic [WIDTH-1:0] data_lsb;
    logic             load_msb;
    logic             load_lsb;
    logic             abort_msb;
    logic             abort_lsb;
    logic             busy_msb;
    logic             busy_lsb;

    int checks = 0;
    int fails  = 0;

    // Model state: the accepted bits of the current word, and expected outputs.
    bit               q[$];
    logic [WIDTH-1:0] m_data_msb;
    logic [WIDTH-1:0] m_data_lsb;
    logic             m_load;
    logic             m_abort;
    logic             m_busy;

    serial_byte_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .data_out  (data_msb),
        .load      (load_msb),
        .abort     (abort_msb),
        .busy      (busy_msb)
    );

    serial_byte_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .data_out  (data_lsb),
        .load      (load_lsb),
        .abort     (abort_lsb),
        .busy      (busy_lsb)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Turn a list of received bits into a word by bit position arithmetic.
    function automatic logic [WIDTH-1:0] packBits(input bit bits[$], input bit msbFirst);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < bits.size(); i++) begin
            if (bits[i]) begin
                if (msbFirst) w = w | (WIDTH'(1) << (WIDTH - 1 - i));
                else          w = w | (WIDTH'(1) << i);
            end
        end
        return w;
    endfunction

    // One comparison: counts it, prints a FAIL line when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a word is whatever WIDTH accepted bits the frame delivered.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_data_msb = '0;
            m_data_lsb = '0;
            m_load     = 1'b0;
            m_abort    = 1'b0;
            m_busy     = 1'b0;
        end else begin
            m_load  = 1'b0;
            m_abort = 1'b0;
            if (frame) begin
                m_busy = 1'b1;
                if (bit_valid) begin
                    q.push_back(bit_in);
                    if (q.size() == WIDTH) begin
                        m_data_msb = packBits(q, 1'b1);
                        m_data_lsb = packBits(q, 1'b0);
                        m_load     = 1'b1;
                        q.delete();
                    end
                end
            end else begin
                m_abort = (q.size() != 0);
                m_busy  = 1'b0;
                q.delete();
            end
        end
    end

    // Compare both instances against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("data_msb",  32'(data_msb),  32'(m_data_msb));
        checkOutput("data_lsb",  32'(data_lsb),  32'(m_data_lsb));
        checkOutput("load_msb",  32'(load_msb),  32'(m_load));
        checkOutput("load_lsb",  32'(load_lsb),  32'(m_load));
        checkOutput("abort_msb", 32'(abort_msb), 32'(m_abort));
        checkOutput("abort_lsb", 32'(abort_lsb), 32'(m_abort));
        checkOutput("busy_msb",  32'(busy_msb),  32'(m_busy));
        checkOutput("busy_lsb",  32'(busy_lsb),  32'(m_busy));
    end

    // Present one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input logic f, input logic v, input logic b);
        @(negedge clk);
        frame     = f;
        bit_valid = v;
        bit_in    = b;
    endtask

    // Send a whole word with frame high, one valid bit per cycle.
    task automatic sendWord(input logic [WIDTH-1:0] bits);
        for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(1'b1, 1'b1, bits[i]);
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        rst       = 1'b0;
        frame     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset data", 32'(data_msb), 32'h0);
        checkOutput("reset busy", 32'(busy_msb), 32'h0);
        rst = 1'b1;

        // Basic word A5.
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendWord(8'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("basic load", 32'(load_msb), 32'h1);
        checkOutput("basic data", 32'(data_msb), 32'hA5);
        checkOutput("basic busy", 32'(busy_msb), 32'h1);

        // Gapped A5: three idle cycles between bits 3 and 4.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("gap no early load", 32'(load_msb), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("gap load", 32'(load_msb), 32'h1);
        checkOutput("gap data", 32'(data_msb), 32'hA5);

        // Abort after three bits, then a 3C frame.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort pulse", 32'(abort_msb), 32'h1);
        checkOutput("abort data held", 32'(data_msb), 32'hA5);
        checkOutput("abort no load", 32'(load_msb), 32'h0);
        sendWord(8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after abort data", 32'(data_msb), 32'h3C);
        checkOutput("silent drop no abort", 32'(abort_msb), 32'h0);

        // Back-to-back A5 then FF with frame held high.
        sendWord(8'hA5);
        sendWord(8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b2b data", 32'(data_msb), 32'hFF);
        checkOutput("b2b load", 32'(load_msb), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Bit order: first bit 1, rest 0.
        sendWord(8'h80);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("order msb", 32'(data_msb), 32'h80);
        checkOutput("order lsb", 32'(data_lsb), 32'h01);

        // Async reset mid-word, asserted between clock edges.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        #2 rst = 1'b0;
        frame = 1'b0;
        #1;
        checkOutput("mid reset data", 32'(data_msb), 32'h0);
        checkOutput("mid reset busy", 32'(busy_msb), 32'h0);
        checkOutput("mid reset load", 32'(load_msb), 32'h0);
        checkOutput("mid reset abort", 32'(abort_msb), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sendWord(8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post reset data", 32'(data_msb), 32'hA5);

        // Randomized traffic with occasional frame drops and resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
